// File: rtl/cpu_types_pkg.sv
// Shared types for the data-request unit of the pipelined MIPS core.
package cpu_types_pkg;

  typedef enum logic [0:0] {DREQ_IDLE, DREQ_PEND} dreq_state_t;

endpackage

// File: rtl/dreq_unit_if.sv
// Datapath <-> data-request unit signal bundle; master is the datapath/cache side.
interface dreq_unit_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);

  logic              ihit;
  logic              dhit;
  logic              dREN;
  logic              dWEN;
  logic              datomic;
  logic [ADDR_W-1:0] daddr;
  logic              halt;
  logic              snoop_inv;
  logic [ADDR_W-1:0] snoop_addr;
  logic              pc_en;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic              sc_valid;
  logic              sc_result;
  logic [CNT_W-1:0]  stall_cycles;
  logic              timeout;

  modport master (
    output ihit, dhit, dREN, dWEN, datomic, daddr, halt, snoop_inv, snoop_addr,
    input  pc_en, dmemREN, dmemWEN, dmemaddr, sc_valid, sc_result, stall_cycles, timeout
  );

  modport slave (
    input  ihit, dhit, dREN, dWEN, datomic, daddr, halt, snoop_inv, snoop_addr,
    output pc_en, dmemREN, dmemWEN, dmemaddr, sc_valid, sc_result, stall_cycles, timeout
  );

endinterface

// File: rtl/link_reg.sv
// LL/SC link register with snoop and plain-store invalidation.
// Only built when DREQ_LLSC_EN is defined.
`ifdef DREQ_LLSC_EN
module link_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ll_set,
  input  logic              sc_clr,
  input  logic              wr_inv,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              link_ok
);

  logic              link_valid;
  logic [ADDR_W-1:0] link_addr;

  // LL set takes priority over any simultaneous invalidation.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (ll_set) begin
      link_valid <= 1'b1;
      link_addr  <= ret_addr;
    end else if (sc_clr ||
                 (snoop_inv && (snoop_addr == link_addr)) ||
                 (wr_inv && (ret_addr == link_addr))) begin
      link_valid <= 1'b0;
    end
  end

  assign link_ok = link_valid && (link_addr == chk_addr);

endmodule
`endif

// File: rtl/dreq_unit.sv
// Holds dmemREN/dmemWEN from ihit launch until dhit retire; gates PC, counts stalls.
// Define DREQ_LLSC_EN to build LL/SC link tracking; otherwise SC behaves as a plain store.
module dreq_unit
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input logic        CLK,
  input logic        nRST,
  dreq_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  dreq_state_t       state;
  logic              ren_q, wen_q, atomic_q;
  logic              sc_valid_q, sc_result_q, timeout_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  stall_q, req_cnt;

  logic idle, launch_req, launch, retire, sc_ok_retire;
  logic atomic_in, sc_fail;

  assign idle         = (state == DREQ_IDLE);
  assign launch_req   = idle && bus.ihit && !bus.halt && (bus.dREN || bus.dWEN);
  assign launch       = launch_req && !sc_fail;
  assign retire       = (state == DREQ_PEND) && bus.dhit;
  assign sc_ok_retire = retire && atomic_q && wen_q;

`ifdef DREQ_LLSC_EN
  logic link_ok;

  assign atomic_in = bus.datomic;
  assign sc_fail   = bus.datomic && bus.dWEN && !link_ok;

  link_reg #(.ADDR_W(ADDR_W)) u_link_reg (
    .CLK        (CLK),
    .nRST       (nRST),
    .ll_set     (retire && atomic_q && ren_q),
    .sc_clr     (sc_ok_retire),
    .wr_inv     (retire && !atomic_q && wen_q),
    .ret_addr   (addr_q),
    .snoop_inv  (bus.snoop_inv),
    .snoop_addr (bus.snoop_addr),
    .chk_addr   (bus.daddr),
    .link_ok    (link_ok)
  );
`else
  logic unused_llsc;

  assign atomic_in   = 1'b0;
  assign sc_fail     = 1'b0;
  assign unused_llsc = ^{bus.datomic, bus.snoop_inv, bus.snoop_addr};
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= DREQ_IDLE;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      atomic_q    <= 1'b0;
      addr_q      <= '0;
      sc_valid_q  <= 1'b0;
      sc_result_q <= 1'b0;
      timeout_q   <= 1'b0;
      stall_q     <= '0;
      req_cnt     <= '0;
    end else begin
      sc_valid_q  <= 1'b0;
      sc_result_q <= 1'b0;
      case (state)
        DREQ_IDLE: begin
          if (launch) begin
            ren_q    <= bus.dREN;
            wen_q    <= bus.dWEN;
            addr_q   <= bus.daddr;
            atomic_q <= atomic_in;
            req_cnt  <= '0;
            state    <= DREQ_PEND;
          end else if (launch_req) begin
            // Failed SC: report immediately, nothing goes to memory.
            sc_valid_q <= 1'b1;
          end
        end
        DREQ_PEND: begin
          if (stall_q != '1) stall_q <= stall_q + CNT_W'(1);
          if (req_cnt != TO_LIM) begin
            req_cnt <= req_cnt + CNT_W'(1);
            if ((req_cnt + CNT_W'(1)) == TO_LIM) timeout_q <= 1'b1;
          end
          if (bus.dhit) begin
            ren_q <= 1'b0;
            wen_q <= 1'b0;
            state <= DREQ_IDLE;
            if (sc_ok_retire) begin
              sc_valid_q  <= 1'b1;
              sc_result_q <= 1'b1;
            end
          end
        end
        default: state <= DREQ_IDLE;
      endcase
    end
  end

  assign bus.pc_en        = idle && bus.ihit && !launch;
  assign bus.dmemREN      = ren_q;
  assign bus.dmemWEN      = wen_q;
  assign bus.dmemaddr     = addr_q;
  assign bus.sc_valid     = sc_valid_q;
  assign bus.sc_result    = sc_result_q;
  assign bus.stall_cycles = stall_q;
  assign bus.timeout      = timeout_q;

endmodule
